// File: rtl/reg_file_32x32_if.sv
// Bus bundle for reg_file_32x32: write port, two read ports and the clear handshake.
// The master side drives requests and addresses; the slave side is the register file.
interface reg_file_32x32_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] rd_addr_a;
    logic [DATA_W-1:0] rd_data_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [DATA_W-1:0] rd_data_b;
    logic              clr_req;
    logic              clr_busy;
    logic              clr_done;

    modport master (
        output wr_valid, wr_addr, wr_data, rd_addr_a, rd_addr_b, clr_req,
        input  wr_ready, rd_data_a, rd_data_b, clr_busy, clr_done
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, rd_addr_a, rd_addr_b, clr_req,
        output wr_ready, rd_data_a, rd_data_b, clr_busy, clr_done
    );
endinterface

// File: rtl/reg_file_32x32.sv
// 32 x 32-bit register file with valid/ready write port, two combinational read ports
// and a one-register-per-cycle clear sequencer. Define WR_BYPASS_EN for write-to-read forwarding.
module reg_file_32x32 #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    reg_file_32x32_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CLEAR = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    logic [DATA_W-1:0] regs [DEPTH];
    logic [1:0]        state;
    logic [ADDR_W-1:0] clr_idx;
    logic              wr_fire;

    assign wr_fire      = bus.wr_valid && bus.wr_ready;
    assign bus.wr_ready = (state == ST_IDLE);
    assign bus.clr_busy = (state == ST_CLEAR);
    assign bus.clr_done = (state == ST_DONE);

    // Leaving CLEAR on the terminal index, never on the index wrapping back to 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            clr_idx <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.clr_req) begin
                        state   <= ST_CLEAR;
                        clr_idx <= '0;
                    end
                end
                ST_CLEAR: begin
                    clr_idx <= clr_idx + 1'b1;
                    if (clr_idx == LAST_IDX) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Writes are only accepted in IDLE, so they can never collide with a clear step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (state == ST_CLEAR) begin
            regs[clr_idx] <= '0;
        end else if (wr_fire) begin
            regs[bus.wr_addr] <= bus.wr_data;
        end
    end

    always_comb begin
        bus.rd_data_a = regs[bus.rd_addr_a];
        bus.rd_data_b = regs[bus.rd_addr_b];
`ifdef WR_BYPASS_EN
        if (wr_fire && (bus.rd_addr_a == bus.wr_addr)) begin
            bus.rd_data_a = bus.wr_data;
        end
        if (wr_fire && (bus.rd_addr_b == bus.wr_addr)) begin
            bus.rd_data_b = bus.wr_data;
        end
`endif
    end
endmodule

// File: tb/tb_reg_file_32x32.sv
// Self-checking bench for reg_file_32x32: directed clear/reset scenarios plus randomized
// read/write traffic against an array model of the 32 registers.
module tb_reg_file_32x32;
    logic clk;
    logic rst_n;

    reg_file_32x32_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    reg_file_32x32 #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] model [32];
    int          total;
    int          bad;
    int          ra;
    int          rb;
    int          wa;
    int          cycles;
    logic [31:0] wd;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    logic        wv;
    bit          bypass;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic checkStatus(input string tag, input logic ready, input logic busy, input logic done);
        checkOutput({tag, ".wr_ready"}, {31'd0, bus.wr_ready}, {31'd0, ready});
        checkOutput({tag, ".clr_busy"}, {31'd0, bus.clr_busy}, {31'd0, busy});
        checkOutput({tag, ".clr_done"}, {31'd0, bus.clr_done}, {31'd0, done});
    endtask

    task automatic applyStimulus(input logic valid, input int addr, input logic [31:0] data);
        bus.wr_valid = valid;
        bus.wr_addr  = 5'(addr);
        bus.wr_data  = data;
    endtask

    // Sweep both read ports across the whole file against the model
    task automatic readAll(input string tag);
        for (int i = 0; i < 32; i++) begin
            bus.rd_addr_a = 5'(i);
            bus.rd_addr_b = 5'(31 - i);
            #1;
            checkOutput({tag, ".rd_a"}, bus.rd_data_a, model[i]);
            checkOutput({tag, ".rd_b"}, bus.rd_data_b, model[31 - i]);
        end
    endtask

    task automatic writeReg(input int addr, input logic [31:0] data);
        applyStimulus(1'b1, addr, data);
        tick();
        bus.wr_valid = 1'b0;
        model[addr] = data;
    endtask

    initial begin
        total  = 0;
        bad    = 0;
`ifdef WR_BYPASS_EN
        bypass = 1'b1;
`else
        bypass = 1'b0;
`endif
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        rst_n         = 1'b0;
        bus.clr_req   = 1'b0;
        bus.rd_addr_a = '0;
        bus.rd_addr_b = '0;
        applyStimulus(1'b0, 0, 32'd0);
        #12;
        rst_n = 1'b1;
        tick();

        $display("[TB] reset state");
        checkStatus("reset", 1'b1, 1'b0, 1'b0);
        readAll("reset");
        tick();

        $display("[TB] directed writes r5 and r31");
        bus.rd_addr_a = 5'd5;
        bus.rd_addr_b = 5'd31;
        writeReg(5, 32'hDEADBEEF);
        checkOutput("r5_after_edge", bus.rd_data_a, 32'hDEADBEEF);
        writeReg(31, 32'h12345678);
        checkOutput("r31_after_edge", bus.rd_data_b, 32'h12345678);
        checkOutput("r5_kept", bus.rd_data_a, 32'hDEADBEEF);

        $display("[TB] randomized traffic");
        for (int n = 0; n < 300; n++) begin
            wv = 1'($urandom_range(1, 0));
            wa = int'($urandom_range(31, 0));
            wd = $urandom;
            ra = int'($urandom_range(31, 0));
            rb = (n % 4 == 0) ? wa : int'($urandom_range(31, 0));
            applyStimulus(wv, wa, wd);
            bus.rd_addr_a = 5'(ra);
            bus.rd_addr_b = 5'(rb);
            #1;
            exp_a = (bypass && wv && ra == wa) ? wd : model[ra];
            exp_b = (bypass && wv && rb == wa) ? wd : model[rb];
            checkOutput("rand.rd_a", bus.rd_data_a, exp_a);
            checkOutput("rand.rd_b", bus.rd_data_b, exp_b);
            tick();
            if (wv) model[wa] = wd;
        end
        bus.wr_valid = 1'b0;
        readAll("rand_final");
        tick();

        $display("[TB] clear sequence over r[i] = i+1");
        for (int i = 0; i < 32; i++) writeReg(i, 32'(i + 1));
        bus.clr_req = 1'b1;
        tick();
        bus.clr_req = 1'b0;
        for (int k = 0; k < 32; k++) begin
            ra = int'($urandom_range(31, 0));
            bus.rd_addr_a = 5'(ra);
            bus.rd_addr_b = 5'(k);
            bus.clr_req = (k == 5);
            #1;
            checkStatus("clear", 1'b0, 1'b1, 1'b0);
            checkOutput("clear.mid_rd_a", bus.rd_data_a, (ra < k) ? 32'd0 : 32'(ra + 1));
            checkOutput("clear.mid_rd_b", bus.rd_data_b, 32'(k + 1));
            tick();
        end
        bus.clr_req = 1'b0;
        checkStatus("clear.done", 1'b0, 1'b0, 1'b1);
        tick();
        checkStatus("clear.idle", 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        readAll("clear.after");
        tick();

        $display("[TB] write held during clear");
        for (int i = 0; i < 32; i++) writeReg(i, $urandom);
        bus.clr_req = 1'b1;
        tick();
        bus.clr_req = 1'b0;
        applyStimulus(1'b1, 7, 32'h0000AAAA);
        bus.rd_addr_a = 5'd7;
        cycles = 0;
        while (!bus.wr_ready && cycles < 100) begin
            tick();
            cycles++;
        end
        checkOutput("hold.wait_cycles", 32'(cycles), 32'd33);
        checkOutput("hold.r7_before", bus.rd_data_a, bypass ? 32'h0000AAAA : 32'd0);
        tick();
        bus.wr_valid = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        model[7] = 32'h0000AAAA;
        checkOutput("hold.r7_after", bus.rd_data_a, 32'h0000AAAA);
        readAll("hold.after");
        tick();

        $display("[TB] clr_req with same-edge write, held through DONE");
        wa = int'($urandom_range(31, 0));
        applyStimulus(1'b1, wa, 32'hCAFEF00D | 32'h1);
        bus.clr_req = 1'b1;
        tick();
        bus.wr_valid = 1'b0;
        for (int k = 0; k < 32; k++) begin
            checkOutput("held.busy", {31'd0, bus.clr_busy}, 32'd1);
            tick();
        end
        checkStatus("held.done", 1'b0, 1'b0, 1'b1);
        tick();
        checkStatus("held.idle", 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        bus.rd_addr_b = 5'(wa);
        #1;
        checkOutput("held.written_cleared", bus.rd_data_b, 32'd0);
        tick();
        checkStatus("held.restart", 1'b0, 1'b1, 1'b0);
        bus.clr_req = 1'b0;
        cycles = 0;
        while (!bus.wr_ready && cycles < 100) begin
            tick();
            cycles++;
        end
        checkOutput("held.restart_len", 32'(cycles), 32'd33);

        $display("[TB] reset mid-clear");
        for (int i = 0; i < 32; i++) writeReg(i, $urandom | 32'h1);
        bus.clr_req = 1'b1;
        tick();
        bus.clr_req = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        bus.rd_addr_a = 5'd10;
        #1;
        checkOutput("rst.r10_not_cleared", bus.rd_data_a, model[10]);
        rst_n = 1'b0;
        #1;
        checkStatus("rst.async", 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        readAll("rst.regs");
        #3;
        rst_n = 1'b1;
        for (int k = 0; k < 40; k++) begin
            tick();
            checkStatus("rst.no_done", 1'b1, 1'b0, 1'b0);
        end

        $display("[TB] same-cycle read/write of r9");
        writeReg(9, 32'h1);
        bus.rd_addr_a = 5'd9;
        bus.rd_addr_b = 5'd9;
        applyStimulus(1'b1, 9, 32'h0F0F0F0F);
        #1;
        checkOutput("same.rd_a", bus.rd_data_a, bypass ? 32'h0F0F0F0F : 32'h1);
        checkOutput("same.rd_b", bus.rd_data_b, bypass ? 32'h0F0F0F0F : 32'h1);
        tick();
        bus.wr_valid = 1'b0;
        checkOutput("same.after", bus.rd_data_a, 32'h0F0F0F0F);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
